// File: rtl/fpu_result_writeback.sv
// In-order result/flag queue between single-cycle FPU datapaths and the register-file write port.
// Optional macro FPU_NANBOX_EN: NaN-box single-precision results (bits [63:32] forced to all ones) on capture.
module fpu_result_writeback #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_result,
    input  logic                       in_is_double,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_flag_invalid,
    input  logic                       in_flag_overflow,
    input  logic                       in_flag_underflow,
    input  logic                       in_flag_inexact,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_result,
    output logic                       out_is_double,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_flags,
    input  logic                       fflags_clr,
    output logic [3:0]                 fflags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [63:0]      result;
        logic             is_double;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            push;
    logic            pop;

    // Handshake: a transfer happens on an edge where valid & ready are both high; valid never
    // waits on ready, and in_ready depends only on registered occupancy (no path from out_ready).
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry.result    = in_result;
        wr_entry.is_double = in_is_double;
        wr_entry.tag       = in_tag;
        wr_entry.flags     = {in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact};
`ifdef FPU_NANBOX_EN
        if (!in_is_double) begin
            wr_entry.result = {32'hFFFF_FFFF, in_result[31:0]};
        end
`else
        wr_entry.result = in_result;
`endif
    end

    // Storage has no reset: only slots between rp and wp are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_entry;
        end
    end

    assign head          = mem[rp];
    assign out_result    = head.result;
    assign out_is_double = head.is_double;
    assign out_tag       = head.tag;
    assign out_flags     = head.flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            fflags <= '0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Flags become architectural only when their entry retires.
            fflags <= (fflags_clr ? 4'b0 : fflags) | (pop ? out_flags : 4'b0);
        end
    end

endmodule

// File: tb/tb_fpu_result_writeback.sv
// Lockstep bench for fpu_result_writeback: reference queue model, vector table, corner sequences, random traffic.
module tb_fpu_result_writeback;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int EW    = 64 + 1 + TAG_W + 4;
`ifdef FPU_NANBOX_EN
    localparam bit NB = 1'b1;
`else
    localparam bit NB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_result;
    logic              in_is_double;
    logic [TAG_W-1:0]  in_tag;
    logic              in_flag_invalid;
    logic              in_flag_overflow;
    logic              in_flag_underflow;
    logic              in_flag_inexact;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_result;
    logic              out_is_double;
    logic [TAG_W-1:0]  out_tag;
    logic [3:0]        out_flags;
    logic              fflags_clr;
    logic [3:0]        fflags;
    logic [$clog2(DEPTH):0] count;

    fpu_result_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_is_double(in_is_double), .in_tag(in_tag),
        .in_flag_invalid(in_flag_invalid), .in_flag_overflow(in_flag_overflow),
        .in_flag_underflow(in_flag_underflow), .in_flag_inexact(in_flag_inexact),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_is_double(out_is_double), .out_tag(out_tag),
        .out_flags(out_flags), .fflags_clr(fflags_clr), .fflags(fflags), .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [3:0]    m_fflags;
    logic [63:0]   drv_exp;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic [63:0]      result;
        logic             dbl;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;
        logic [63:0]      exp_result;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [63:0] exp_res(input logic [63:0] r, input logic d);
        if (NB && !d) return {32'hFFFF_FFFF, r[31:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [63:0] r, input logic d,
                         input logic [TAG_W-1:0] t, input logic [3:0] f);
        in_valid          = v;
        in_result         = r;
        in_is_double      = d;
        in_tag            = t;
        {in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact} = f;
        drv_exp           = exp_res(r, d);
    endtask

    // Check outputs against the model, then advance DUT and model by one edge.
    task automatic tick();
        bit m_ready;
        bit m_valid;
        bit push;
        bit pop;
        m_ready = (exp_q.size() != DEPTH);
        m_valid = (exp_q.size() != 0);
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_valid);
        chk("count", count, exp_q.size());
        chk("fflags", fflags, m_fflags);
        if (m_valid) chk("head_entry", {out_result, out_is_double, out_tag, out_flags}, exp_q[0]);
        push = in_valid && m_ready;
        pop  = m_valid && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_fflags = 4'b0;
        end else begin
            m_fflags = (fflags_clr ? 4'b0 : m_fflags) | (pop ? exp_q[0][3:0] : 4'b0);
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({drv_exp, in_is_double, in_tag,
                in_flag_invalid, in_flag_overflow, in_flag_underflow, in_flag_inexact});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 64'h0, 1'b0, '0, 4'b0);
        out_ready = ordy;
        tick();
    endtask

    initial begin
        vecs[0] = '{64'h3FF8_0000_0000_0000, 1'b1, 5'd3,  4'b0001, 64'h3FF8_0000_0000_0000};
        vecs[1] = '{64'h0000_0000_3FC0_0000, 1'b0, 5'd7,  4'b0000,
                    NB ? 64'hFFFF_FFFF_3FC0_0000 : 64'h0000_0000_3FC0_0000};
        vecs[2] = '{64'hDEAD_BEEF_4049_0FDB, 1'b0, 5'd31, 4'b1010,
                    NB ? 64'hFFFF_FFFF_4049_0FDB : 64'hDEAD_BEEF_4049_0FDB};
        vecs[3] = '{64'h7FF0_0000_0000_0000, 1'b1, 5'd0,  4'b0100, 64'h7FF0_0000_0000_0000};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd16, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{64'h0000_0000_0000_0000, 1'b0, 5'd1,  4'b0010,
                    NB ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_0000_0000};

        rst_n = 1'b0;
        fflags_clr = 1'b0;
        out_ready = 1'b0;
        m_fflags = 4'b0;
        drive(1'b0, 64'h0, 1'b0, '0, 4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state, then single push / pop from the test plan
        idle(1'b0);
        drive(1'b1, 64'h3FF8_0000_0000_0000, 1'b1, 5'd3, 4'b0001);
        out_ready = 1'b0;
        tick();
        idle(1'b1);
        idle(1'b0);
        chk("fflags_single", fflags, 4'b0001);

        // vector table: push each entry, let it sit one cycle, retire it
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].result, vecs[i].dbl, vecs[i].tag, vecs[i].flags);
            drv_exp = vecs[i].exp_result;
            out_ready = 1'b0;
            tick();
            chk("vec_result", out_result, vecs[i].exp_result);
            idle(1'b1);
        end
        idle(1'b0);

        // fill to full, a 5th push is refused, drain in order, then wrap
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 64'h1000 + 64'(t), 1'b1, TAG_W'(t), 4'b0);
            out_ready = 1'b0;
            tick();
        end
        drive(1'b1, 64'hBAD, 1'b1, 5'd9, 4'b0);
        tick();
        chk("full_in_ready", in_ready, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            chk("drain_tag", out_tag, TAG_W'(t));
            idle(1'b1);
        end
        drive(1'b1, 64'h5555, 1'b1, 5'd5, 4'b0);
        out_ready = 1'b0;
        tick();
        chk("wrap_tag", out_tag, 5'd5);
        idle(1'b1);

        // full with simultaneous push and pop: pop only, push lands next cycle
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 64'h2000 + 64'(t), 1'b0, TAG_W'(10 + t), 4'b0);
            out_ready = 1'b0;
            tick();
        end
        drive(1'b1, 64'h2AAA, 1'b1, 5'd20, 4'b0);
        out_ready = 1'b1;
        tick();
        chk("full_pop_count", count, 3);
        out_ready = 1'b0;
        tick();
        chk("refill_count", count, 4);
        repeat (4) idle(1'b1);

        // sticky flags and clear-with-retire
        fflags_clr = 1'b1;
        idle(1'b0);
        fflags_clr = 1'b0;
        drive(1'b1, 64'h1, 1'b1, 5'd1, 4'b1000); out_ready = 1'b0; tick();
        drive(1'b1, 64'h2, 1'b1, 5'd2, 4'b0100); tick();
        drive(1'b1, 64'h3, 1'b1, 5'd3, 4'b0010); tick();
        idle(1'b1);
        idle(1'b1);
        chk("sticky_or", fflags, 4'b1100);
        fflags_clr = 1'b1;
        idle(1'b1);
        fflags_clr = 1'b0;
        chk("clr_with_retire", fflags, 4'b0010);
        idle(1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                  TAG_W'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            out_ready  = 1'($urandom_range(0, 3) != 0);
            fflags_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        fflags_clr = 1'b0;
        repeat (DEPTH + 1) idle(1'b1);

        // reset with 3 queued entries and all sticky flags set
        drive(1'b1, 64'hF, 1'b1, 5'd30, 4'b1111); out_ready = 1'b0; tick();
        idle(1'b1);
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 64'hE0 + 64'(t), 1'b1, TAG_W'(24 + t), 4'b0101);
            out_ready = 1'b0;
            tick();
        end
        chk("pre_reset_fflags", fflags, 4'b1111);
        chk("pre_reset_count", count, 3);
        drive(1'b0, 64'h0, 1'b0, '0, 4'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_fflags", fflags, 4'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b1, 5'd8, 4'b0001);
        tick();
        chk("post_reset_tag", out_tag, 5'd8);
        idle(1'b1);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
